// File: rtl/indirect_iter_sched_pkg.sv
// Shared configuration for the indirect (feature-match) pose solver.
// Holds the pair-buffer geometry, datapath latency, field widths, the pose
// type and the iteration sequencer state encoding.
package indirect_iter_sched_pkg;

  localparam int MAX_PAIRS     = 1024;
  localparam int ADDR_BW       = $clog2(MAX_PAIRS);
  localparam int CNT_BW        = $clog2(MAX_PAIRS + 1);
  localparam int PIPE_LAT      = 12;

  localparam int POSE_BW       = 32;
  localparam int POSE_WORDS    = 12;
  localparam int H_SIZE_BW     = 11;
  localparam int V_SIZE_BW     = 10;
  localparam int DATA_DEPTH_BW = 16;

  typedef logic [POSE_WORDS-1:0][POSE_BW-1:0] pose_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_WAIT_SOLVE = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Producer guarantees n <= MAX_PAIRS; anything larger is clamped so the
  // read address can never wrap.
  function automatic logic [CNT_BW-1:0] clamp_pairs(input logic [CNT_BW-1:0] n);
    return (n > CNT_BW'(MAX_PAIRS)) ? CNT_BW'(MAX_PAIRS) : n;
  endfunction

endpackage

// File: rtl/indirect_iter_sched_if.sv
// Pair-buffer read port plus the datapath stream toward the indirect-calc
// pipeline.
//   master : sequencer side (drives o_*, receives i_rd_*)
//   slave  : pair buffer / datapath side
// Handshake: push-only, no backpressure. o_rd_en is a read strobe whose data
// returns RD_LAT cycles later on i_rd_*. o_valid qualifies o_idx*/o_depth0 and
// the frame flags for exactly that cycle; the consumer must accept every beat.
interface indirect_iter_sched_if;
  import indirect_iter_sched_pkg::*;

  logic                     o_rd_en;
  logic [ADDR_BW-1:0]       o_rd_addr;
  logic [H_SIZE_BW-1:0]     i_rd_idx0_x;
  logic [V_SIZE_BW-1:0]     i_rd_idx0_y;
  logic [DATA_DEPTH_BW-1:0] i_rd_depth0;
  logic [H_SIZE_BW-1:0]     i_rd_idx1_x;
  logic [V_SIZE_BW-1:0]     i_rd_idx1_y;

  logic                     o_valid;
  logic                     o_frame_start;
  logic                     o_frame_end;
  logic [H_SIZE_BW-1:0]     o_idx0_x;
  logic [V_SIZE_BW-1:0]     o_idx0_y;
  logic [DATA_DEPTH_BW-1:0] o_depth0;
  logic [H_SIZE_BW-1:0]     o_idx1_x;
  logic [V_SIZE_BW-1:0]     o_idx1_y;

  modport master (
    output o_rd_en, o_rd_addr,
    output o_valid, o_frame_start, o_frame_end,
    output o_idx0_x, o_idx0_y, o_depth0, o_idx1_x, o_idx1_y,
    input  i_rd_idx0_x, i_rd_idx0_y, i_rd_depth0, i_rd_idx1_x, i_rd_idx1_y
  );

  modport slave (
    input  o_rd_en, o_rd_addr,
    input  o_valid, o_frame_start, o_frame_end,
    input  o_idx0_x, o_idx0_y, o_depth0, o_idx1_x, o_idx1_y,
    output i_rd_idx0_x, i_rd_idx0_y, i_rd_depth0, i_rd_idx1_x, i_rd_idx1_y
  );

endinterface

// File: rtl/indirect_iter_sched_pair_reader.sv
// indirect_pair_reader: issues one burst of N consecutive pair-buffer reads
// (addresses 0..N-1), aligns the returned data with a RD_LAT-deep valid/frame
// pipe and registers it once onto the datapath stream.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_go         : one-cycle pulse, first read happens the following cycle
//   i_flush      : drops the burst and everything in flight
//   i_num        : pair count for this burst (already clamped, >= 1)
//   o_last       : current cycle carries the final read of the burst
//   bus          : read port + stream (master side)
module indirect_pair_reader
  import indirect_iter_sched_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic              i_flush,
  input  logic [CNT_BW-1:0] i_num,
  output logic              o_last,
  indirect_iter_sched_if.master bus
);

  logic               rd_en_q;
  logic [ADDR_BW-1:0] addr_q;
  logic [RD_LAT-1:0]  v_pipe;
  logic [RD_LAT-1:0]  s_pipe;
  logic [RD_LAT-1:0]  e_pipe;
  logic               first_rd;

  assign o_last        = rd_en_q && (CNT_BW'(addr_q) == (i_num - CNT_BW'(1)));
  assign first_rd      = rd_en_q && (addr_q == '0);
  assign bus.o_rd_en   = rd_en_q;
  assign bus.o_rd_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_en_q           <= 1'b0;
      addr_q            <= '0;
      v_pipe            <= '0;
      s_pipe            <= '0;
      e_pipe            <= '0;
      bus.o_valid       <= 1'b0;
      bus.o_frame_start <= 1'b0;
      bus.o_frame_end   <= 1'b0;
      bus.o_idx0_x      <= '0;
      bus.o_idx0_y      <= '0;
      bus.o_depth0      <= '0;
      bus.o_idx1_x      <= '0;
      bus.o_idx1_y      <= '0;
    end else begin
      if (i_go) begin
        rd_en_q <= 1'b1;
        addr_q  <= '0;
      end else if (rd_en_q) begin
        if (o_last) rd_en_q <= 1'b0;
        else        addr_q  <= addr_q + ADDR_BW'(1);
      end

      // Frame flags ride alongside the strobe so they stay aligned with
      // the data whatever RD_LAT is.
      v_pipe[0] <= rd_en_q;
      s_pipe[0] <= first_rd;
      e_pipe[0] <= o_last;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end

      bus.o_valid       <= v_pipe[RD_LAT-1];
      bus.o_frame_start <= s_pipe[RD_LAT-1];
      bus.o_frame_end   <= e_pipe[RD_LAT-1];
      if (v_pipe[RD_LAT-1]) begin
        bus.o_idx0_x <= bus.i_rd_idx0_x;
        bus.o_idx0_y <= bus.i_rd_idx0_y;
        bus.o_depth0 <= bus.i_rd_depth0;
        bus.o_idx1_x <= bus.i_rd_idx1_x;
        bus.o_idx1_y <= bus.i_rd_idx1_y;
      end
    end
  end

endmodule

// File: rtl/indirect_iter_sched.sv
// indirect_iter_sched: per-iteration sequencer of the indirect pose solver.
// Each iteration: LOAD the pose, ISSUE N pair reads, DRAIN the datapath,
// WAIT_SOLVE for the updated pose; repeat until converged or iteration limit.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_start, i_abort       : sequence control (abort has priority)
//   i_num_pairs, i_max_iter, i_init_pose : sampled on an accepted start
//   i_pose_valid, i_pose_new, i_converged : solver result
//   bus                    : pair-buffer read port + datapath stream
//   o_pose                 : pose held stable for the running iteration
//   o_busy, o_done, o_iter_cnt, o_err_empty : status
//   o_state                : FSM state (debug)
module indirect_iter_sched
  import indirect_iter_sched_pkg::*;
#(
  parameter int ITER_BW = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [CNT_BW-1:0]  i_num_pairs,
  input  logic [ITER_BW-1:0] i_max_iter,
  input  pose_t              i_init_pose,
  input  logic               i_pose_valid,
  input  pose_t              i_pose_new,
  input  logic               i_converged,
  indirect_iter_sched_if.master bus,
  output pose_t              o_pose,
  output logic               o_busy,
  output logic               o_done,
  output logic [ITER_BW-1:0] o_iter_cnt,
  output logic               o_err_empty,
  output state_t             o_state
);

  // Last read -> WAIT_SOLVE spans read latency, output register and pipeline.
  localparam int DRAIN_CYC = RD_LAT + 1 + PIPE_LAT;
  localparam int DRAIN_BW  = $clog2(DRAIN_CYC);

  state_t             state_q, state_d;
  logic [CNT_BW-1:0]  num_q;
  logic [ITER_BW-1:0] max_iter_q;
  pose_t              init_pose_q;
  logic               first_iter_q;
  logic [DRAIN_BW-1:0] drain_q;
  logic               start_ok;
  logic               rd_last;
  logic [ITER_BW:0]   iter_inc;
  logic               solve_end;

  assign start_ok  = (state_q == ST_IDLE) && i_start && !i_abort;
  assign iter_inc  = {1'b0, o_iter_cnt} + (ITER_BW+1)'(1);
  assign solve_end = i_converged || (iter_inc == {1'b0, max_iter_q});
  assign o_state   = state_q;

  indirect_pair_reader #(.RD_LAT(RD_LAT)) u_reader (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_go    ((state_q == ST_LOAD) && !i_abort),
    .i_flush (i_abort),
    .i_num   (num_q),
    .o_last  (rd_last),
    .bus     (bus)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start_ok) state_d = (i_num_pairs == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:       state_d = ST_ISSUE;
      ST_ISSUE:      if (rd_last) state_d = ST_DRAIN;
      ST_DRAIN:      if (drain_q == '0) state_d = ST_WAIT_SOLVE;
      ST_WAIT_SOLVE: if (i_pose_valid) state_d = solve_end ? ST_DONE : ST_LOAD;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (i_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      max_iter_q   <= '0;
      init_pose_q  <= '0;
      first_iter_q <= 1'b0;
      drain_q      <= '0;
      o_pose       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_iter_cnt   <= '0;
      o_err_empty  <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_busy      <= (state_d != ST_IDLE);
      o_done      <= (state_d == ST_DONE);
      o_err_empty <= start_ok && (i_num_pairs == '0);

      if (start_ok) begin
        num_q        <= clamp_pairs(i_num_pairs);
        max_iter_q   <= (i_max_iter == '0) ? ITER_BW'(1) : i_max_iter;
        init_pose_q  <= i_init_pose;
        first_iter_q <= 1'b1;
        o_iter_cnt   <= '0;
      end

      // Abort freezes pose and iteration count where they are.
      if (!i_abort) begin
        case (state_q)
          ST_LOAD: begin
            if (first_iter_q) o_pose <= init_pose_q;
            first_iter_q <= 1'b0;
          end
          ST_ISSUE: drain_q <= DRAIN_BW'(DRAIN_CYC - 2);
          ST_DRAIN: if (drain_q != '0) drain_q <= drain_q - DRAIN_BW'(1);
          ST_WAIT_SOLVE: begin
            if (i_pose_valid) begin
              o_pose <= i_pose_new;
              if (o_iter_cnt != '1) o_iter_cnt <= o_iter_cnt + ITER_BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_indirect_iter_sched.sv
// Directed bench for indirect_iter_sched: table of sequence vectors plus
// hand-written sequences for empty start, abort+start and reset.
module tb_indirect_iter_sched;
  import indirect_iter_sched_pkg::*;

  localparam int ITER_BW = 4;
  localparam int BUDGET  = 4000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_start, i_abort, i_pose_valid, i_converged;
  logic [CNT_BW-1:0]  i_num_pairs;
  logic [ITER_BW-1:0] i_max_iter;
  pose_t              i_init_pose, i_pose_new, o_pose;
  logic               o_busy, o_done, o_err_empty;
  logic [ITER_BW-1:0] o_iter_cnt;
  state_t             o_state;

  indirect_iter_sched_if bus();

  indirect_iter_sched #(.ITER_BW(ITER_BW), .RD_LAT(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_num_pairs  (i_num_pairs),
    .i_max_iter   (i_max_iter),
    .i_init_pose  (i_init_pose),
    .i_pose_valid (i_pose_valid),
    .i_pose_new   (i_pose_new),
    .i_converged  (i_converged),
    .bus          (bus),
    .o_pose       (o_pose),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_iter_cnt   (o_iter_cnt),
    .o_err_empty  (o_err_empty),
    .o_state      (o_state)
  );

  // ---------------- pair buffer model (1-cycle read) ----------------
  function automatic logic [H_SIZE_BW-1:0] f_x0(int a);
    return H_SIZE_BW'(a ^ 'h155);
  endfunction
  function automatic logic [V_SIZE_BW-1:0] f_y0(int a);
    return V_SIZE_BW'(a + 7);
  endfunction
  function automatic logic [DATA_DEPTH_BW-1:0] f_d0(int a);
    return DATA_DEPTH_BW'(a * 37 + 5);
  endfunction
  function automatic logic [H_SIZE_BW-1:0] f_x1(int a);
    return H_SIZE_BW'(a * 3);
  endfunction
  function automatic logic [V_SIZE_BW-1:0] f_y1(int a);
    return V_SIZE_BW'(1000 - a);
  endfunction

  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bus.i_rd_idx0_x <= f_x0(int'(bus.o_rd_addr));
      bus.i_rd_idx0_y <= f_y0(int'(bus.o_rd_addr));
      bus.i_rd_depth0 <= f_d0(int'(bus.o_rd_addr));
      bus.i_rd_idx1_x <= f_x1(int'(bus.o_rd_addr));
      bus.i_rd_idx1_y <= f_y1(int'(bus.o_rd_addr));
    end
  end

  function automatic pose_t make_pose(int k);
    pose_t p;
    for (int w = 0; w < POSE_WORDS; w++) p[w] = {8'(k), 8'(w), 16'hA5C3};
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_pose(input string nm, input pose_t act, input pose_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int num;
    int max_iter;
    int conv_at;     // result index (1-based) that reports convergence, 0 = never
    int dly;         // extra WAIT_SOLVE cycles before the solver answers
    int abort_k;     // iteration in which to abort after 3 reads, -1 = none
    int exp_iter;
    int exp_streams;
  } vec_t;

  vec_t vecs[9];

  task automatic run_seq(input int vi, input vec_t v);
    int n_eff, k, rd_cnt, v_cnt, first_rd, last_rd, pv_cyc, streams, quiet;
    bit done, aborted;
    n_eff   = (v.num > MAX_PAIRS) ? MAX_PAIRS : v.num;
    k = 0; rd_cnt = 0; v_cnt = 0; first_rd = -100; last_rd = -100;
    pv_cyc = -100; streams = 0; done = 0; aborted = 0;

    i_num_pairs = CNT_BW'(v.num);
    i_max_iter  = ITER_BW'(v.max_iter);
    i_init_pose = make_pose(0);
    i_start     = 1'b1;
    step();
    i_start = 1'b0;
    chk($sformatf("v%0d_load_state", vi), o_state, ST_LOAD);
    chk($sformatf("v%0d_busy", vi), o_busy, 1);
    chk($sformatf("v%0d_iter_clr", vi), o_iter_cnt, 0);

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (aborted) begin
        i_abort = 1'b0;
        chk($sformatf("v%0d_abort_rd_en", vi), bus.o_rd_en, 0);
        chk($sformatf("v%0d_abort_valid", vi), bus.o_valid, 0);
        chk($sformatf("v%0d_abort_fe", vi), bus.o_frame_end, 0);
        chk($sformatf("v%0d_abort_busy", vi), o_busy, 0);
        chk($sformatf("v%0d_abort_state", vi), o_state, ST_IDLE);
        break;
      end
      i_pose_valid = 1'b0;
      i_converged  = 1'b0;
      i_start      = 1'b0;

      if (bus.o_rd_en) begin
        chk($sformatf("v%0d_k%0d_rd_addr", vi, k), bus.o_rd_addr, rd_cnt);
        if (rd_cnt == 0) first_rd = cyc;
        rd_cnt++;
        if (rd_cnt == n_eff) last_rd = cyc;
        if (k == v.abort_k && rd_cnt == 3) begin
          i_abort = 1'b1;
          aborted = 1;
        end
      end

      if (bus.o_valid) begin
        chk($sformatf("v%0d_k%0d_valid_time", vi, k), cyc, first_rd + 2 + v_cnt);
        chk($sformatf("v%0d_k%0d_fs", vi, k), bus.o_frame_start, (v_cnt == 0));
        chk($sformatf("v%0d_k%0d_fe", vi, k), bus.o_frame_end, (v_cnt == n_eff - 1));
        chk($sformatf("v%0d_idx0_x", vi), bus.o_idx0_x, f_x0(v_cnt));
        chk($sformatf("v%0d_idx0_y", vi), bus.o_idx0_y, f_y0(v_cnt));
        chk($sformatf("v%0d_depth0", vi), bus.o_depth0, f_d0(v_cnt));
        chk($sformatf("v%0d_idx1_x", vi), bus.o_idx1_x, f_x1(v_cnt));
        chk($sformatf("v%0d_idx1_y", vi), bus.o_idx1_y, f_y1(v_cnt));
        chk_pose($sformatf("v%0d_k%0d_pose", vi, k), o_pose, make_pose(k));
        v_cnt++;
      end

      if (rd_cnt == n_eff && cyc == last_rd + 13)
        chk($sformatf("v%0d_k%0d_drain", vi, k), o_state, ST_DRAIN);
      if (rd_cnt == n_eff && cyc == last_rd + 14) begin
        chk($sformatf("v%0d_k%0d_wait", vi, k), o_state, ST_WAIT_SOLVE);
        chk($sformatf("v%0d_k%0d_valid_cnt", vi, k), v_cnt, n_eff);
        chk($sformatf("v%0d_k%0d_iter", vi, k), o_iter_cnt, k);
      end
      if (rd_cnt == n_eff && cyc == last_rd + 14 + v.dly) begin
        i_pose_valid = 1'b1;
        i_pose_new   = make_pose(k + 1);
        i_converged  = (k + 1 == v.conv_at);
        i_start      = 1'b1;              // must be ignored while busy
        i_num_pairs  = CNT_BW'(7);
        pv_cyc  = cyc;
        k++;
        streams++;
        rd_cnt  = 0;
        v_cnt   = 0;
      end

      if (o_done) begin
        done = 1;
        chk($sformatf("v%0d_done_latency", vi), cyc, pv_cyc + 1);
        break;
      end
      step();
    end

    chk($sformatf("v%0d_streams", vi), streams, v.exp_streams);
    chk($sformatf("v%0d_iter_final", vi), o_iter_cnt, v.exp_iter);
    chk_pose($sformatf("v%0d_pose_final", vi), o_pose, make_pose(v.exp_iter));

    if (v.abort_k >= 0) begin
      quiet = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (bus.o_rd_en || bus.o_valid || bus.o_frame_end || o_done) quiet++;
      end
      chk($sformatf("v%0d_abort_quiet", vi), quiet, 0);
    end else begin
      chk($sformatf("v%0d_done_seen", vi), done, 1);
      chk($sformatf("v%0d_done_busy", vi), o_busy, 1);
      chk($sformatf("v%0d_no_err", vi), o_err_empty, 0);
      step();
      chk($sformatf("v%0d_done_pulse", vi), o_done, 0);
      chk($sformatf("v%0d_idle_busy", vi), o_busy, 0);
      chk($sformatf("v%0d_idle_state", vi), o_state, ST_IDLE);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int act;
    vecs[0] = '{5,    1, 0, 0, -1, 1, 1};
    vecs[1] = '{1,    1, 0, 2, -1, 1, 1};
    vecs[2] = '{3,    4, 0, 0, -1, 4, 4};
    vecs[3] = '{3,    4, 2, 1, -1, 2, 2};
    vecs[4] = '{2,    0, 0, 0, -1, 1, 1};
    vecs[5] = '{2000, 1, 0, 0, -1, 1, 1};
    vecs[6] = '{8,    2, 0, 0,  0, 0, 0};
    vecs[7] = '{8,    2, 0, 0,  1, 1, 1};
    vecs[8] = '{4,    1, 0, 0, -1, 1, 1};

    rst = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_pose_valid = 1'b0; i_converged = 1'b0;
    i_num_pairs = '0; i_max_iter = '0; i_init_pose = '0; i_pose_new = '0;
    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd_en", bus.o_rd_en, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_iter", o_iter_cnt, 0);
    chk("rst_err", o_err_empty, 0);
    chk("rst_state", o_state, ST_IDLE);
    chk_pose("rst_pose", o_pose, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_seq(i, vecs[i]);
      repeat (2) step();
    end

    // Empty start: error + done pulse, one busy cycle, no reads.
    i_num_pairs = '0;
    i_max_iter  = 4'd3;
    i_start     = 1'b1;
    step();
    i_start = 1'b0;
    chk("empty_err", o_err_empty, 1);
    chk("empty_done", o_done, 1);
    chk("empty_busy", o_busy, 1);
    chk("empty_state", o_state, ST_DONE);
    chk("empty_rd_en", bus.o_rd_en, 0);
    chk("empty_iter_clr", o_iter_cnt, 0);
    step();
    chk("empty_err_pulse", o_err_empty, 0);
    chk("empty_done_pulse", o_done, 0);
    chk("empty_busy_end", o_busy, 0);
    act = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.o_rd_en || o_busy) act++;
    end
    chk("empty_quiet", act, 0);

    // Abort and start together while idle: start is dropped.
    i_num_pairs = CNT_BW'(4);
    i_max_iter  = 4'd1;
    i_start     = 1'b1;
    i_abort     = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abort_start_busy", o_busy, 0);
    chk("abort_start_state", o_state, ST_IDLE);
    act = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.o_rd_en || bus.o_valid || o_busy) act++;
    end
    chk("abort_start_quiet", act, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
